frame_dump_seq: RTL and testbench

- Readout sequencer between the downsampled-frame buffer and the byte UART transmitter in the icebreaker camera test design.
- On a start request it sends a 4-byte sync header, then walks the buffer in raster order (y outer, x inner), reading one 32-bit word per location and sending its 4 bytes MSB-first.
- It paces bytes with a UART busy/holdoff handshake, so a host can re-frame the stream.
- Runs entirely in the UART (read) clock domain.

---
 rtl/cam_dump_pkg.sv | 6 +
 rtl/frame_dump_seq_uart_pacer.sv | 30 +++
 rtl/frame_dump_seq.sv | 110 +++++++++++
 tb/tb_frame_dump_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_dump_pkg.sv
// cam_dump_pkg: shared state type and constants for the frame dump sequencer
package cam_dump_pkg;
    typedef enum logic [2:0] {IDLE, HDR, ADDR, LATCH, SEND} state_t;
    localparam logic [31:0] SYNC_DEFAULT = 32'hA55A_F00F;
    localparam int IDX_W = 2;
endpackage

// File: rtl/frame_dump_seq_uart_pacer.sv
// uart_pacer: inter-byte holdoff counter and write strobe generation
//   i_clk, i_rst     clock, async active-high reset
//   i_uart_busy      UART transmitting
//   i_want_send      sequencer has a byte to send
//   o_wr             write strobe, high only when the holdoff has fully elapsed
module uart_pacer
    import cam_dump_pkg::*;
#(
    parameter int HOLDOFF_BITS = 13
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_uart_busy,
    input  logic i_want_send,
    output logic o_wr
);
    logic [HOLDOFF_BITS-1:0] r_cnt;

    // Strobe is combinational so the counter restarts in the strobe cycle,
    // giving a spacing of exactly 2**HOLDOFF_BITS cycles on an idle UART.
    assign o_wr = i_want_send && (&r_cnt) && !i_uart_busy;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_cnt <= '0;
        else if (i_uart_busy || o_wr)
            r_cnt <= '0;
        else if (!(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/frame_dump_seq.sv
// frame_dump_seq: streams a sync header then the frame buffer, MSB-first, to a byte UART
//   sys_clk_i, sys_rst_i     read clock, async active-high reset
//   start_i                  request a dump (ignored when AUTO or busy)
//   read_x_o, read_y_o       buffer address; read_q_i valid one cycle later
//   uart_dat_o, uart_wr_o    byte and single-cycle write strobe
//   uart_busy_i              UART transmitting
//   busy_o, frame_done_o     dump in progress, pulse after last byte
module frame_dump_seq
    import cam_dump_pkg::*;
#(
    parameter int          COLS         = 40,
    parameter int          ROWS         = 30,
    parameter int          XW           = 6,
    parameter int          YW           = 5,
    parameter int          HOLDOFF_BITS = 13,
    parameter logic [31:0] SYNC_WORD    = SYNC_DEFAULT,
    parameter int          AUTO         = 1
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          start_i,
    output logic [XW-1:0] read_x_o,
    output logic [YW-1:0] read_y_o,
    input  logic [31:0]   read_q_i,
    output logic [7:0]    uart_dat_o,
    output logic          uart_wr_o,
    input  logic          uart_busy_i,
    output logic          busy_o,
    output logic          frame_done_o
);
    state_t           r_state, w_next;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_word;
    logic             r_done;
    logic             w_want, w_wr, w_last_byte, w_last_x, w_last_y, w_last_word;
    logic [31:0]      w_src;

    assign w_want      = (r_state == HDR) || (r_state == SEND);
    assign w_last_byte = w_wr && (&r_idx);
    assign w_last_x    = r_x == XW'(COLS - 1);
    assign w_last_y    = r_y == YW'(ROWS - 1);
    assign w_last_word = (r_state == SEND) && w_last_byte && w_last_x && w_last_y;
    assign w_src       = (r_state == HDR) ? SYNC_WORD : r_word;

    uart_pacer #(.HOLDOFF_BITS(HOLDOFF_BITS)) u_pacer (
        .i_clk       (sys_clk_i),
        .i_rst       (sys_rst_i),
        .i_uart_busy (uart_busy_i),
        .i_want_send (w_want),
        .o_wr        (w_wr)
    );

    // Byte index 0 selects bits [31:24], so the offset is (3 - idx) * 8.
    assign uart_dat_o   = w_wr ? w_src[{~r_idx, 3'b000} +: 8] : 8'h00;
    assign uart_wr_o    = w_wr;
    assign busy_o       = r_state != IDLE;
    assign frame_done_o = r_done;
    assign read_x_o     = r_x;
    assign read_y_o     = r_y;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        if (sys_rst_i)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (AUTO != 0 || start_i) ? HDR : IDLE;
            HDR:     w_next = w_last_byte ? ADDR : HDR;
            ADDR:    w_next = LATCH;
            LATCH:   w_next = SEND;
            SEND:    w_next = !w_last_byte ? SEND : (w_last_word ? IDLE : ADDR);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        if (sys_rst_i) begin
            r_x    <= '0;
            r_y    <= '0;
            r_idx  <= '0;
            r_word <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_word;
            if (r_state == IDLE && w_next == HDR) begin
                r_x   <= '0;
                r_y   <= '0;
                r_idx <= '0;
            end else if (r_state == LATCH) begin
                r_word <= read_q_i;
                r_idx  <= '0;
            end else if (w_wr) begin
                r_idx <= r_idx + 1'b1;
            end
            // Address advances only when leaving a fully sent word.
            if (r_state == SEND && w_last_byte && !w_last_word) begin
                if (w_last_x) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_frame_dump_seq.sv
// tb_frame_dump_seq: self-checking bench for frame_dump_seq (manual 2x2 and auto 1x1 instances)
module tb_frame_dump_seq;
    logic        clk = 0, rst = 0, start_a = 0, busy_en = 0;
    logic [5:0]  xa, xb;
    logic [4:0]  ya, yb;
    logic [31:0] qa, qb;
    logic [7:0]  data, datb;
    logic        wra, wrb, ubusy_a, busya, busyb, donea, doneb;
    logic [10:0] pa, pb;
    int          bcnt = 0, cyc = 0;
    int          checks = 0, failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  log_a[$];
    int          n_done = 0, frame_pos = 0, last_cyc = 0, last_gap = 0;
    logic        prev_wra = 0, prev_busya = 0;
    int          kb = 0, nb_in = 0, b_done = 0, lastb = 0;
    logic        first_b = 1, prev_doneb = 0;
    logic [7:0]  exp_b [8] = '{8'hA5, 8'h5A, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'hC3, 8'h3C};

    frame_dump_seq #(.COLS(2), .ROWS(2), .XW(6), .YW(5), .HOLDOFF_BITS(3), .AUTO(0)) dut_a (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start_a),
        .read_x_o(xa), .read_y_o(ya), .read_q_i(qa),
        .uart_dat_o(data), .uart_wr_o(wra), .uart_busy_i(ubusy_a),
        .busy_o(busya), .frame_done_o(donea));

    frame_dump_seq #(.COLS(1), .ROWS(1), .XW(6), .YW(5), .HOLDOFF_BITS(3), .AUTO(1)) dut_b (
        .sys_clk_i(clk), .sys_rst_i(rst), .start_i(1'b0),
        .read_x_o(xb), .read_y_o(yb), .read_q_i(qb),
        .uart_dat_o(datb), .uart_wr_o(wrb), .uart_busy_i(1'b0),
        .busy_o(busyb), .frame_done_o(doneb));

    always #5 clk = ~clk;

    function automatic logic [31:0] buf_word(input logic [5:0] x, input logic [4:0] y);
        return {3'b000, y, 2'b00, x, 8'hC3, 8'h3C};
    endfunction

    // Buffer returns garbage in the cycle its address changes, real data afterwards.
    always_ff @(posedge clk) begin
        pa   <= {xa, ya};
        pb   <= {xb, yb};
        cyc  <= cyc + 1;
        bcnt <= (wra && busy_en) ? 10 : (bcnt > 0 ? bcnt - 1 : 0);
    end
    assign qa = ({xa, ya} != pa) ? 32'hDEAD_BEEF : buf_word(xa, ya);
    assign qb = ({xb, yb} != pb) ? 32'hDEAD_BEEF : buf_word(xb, yb);
    assign ubusy_a = bcnt != 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic load_frame();
        push_word(32'hA55A_F00F);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++)
                push_word(buf_word(6'(x), 5'(y)));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_a = 1;
        @(posedge clk); #1 start_a = 0;
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (log_a.size() < n && t < 5000) begin @(negedge clk); t++; end
        chk("wait_strobes", log_a.size() >= n, 1);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (n_done < n && t < 5000) begin @(negedge clk); t++; end
        chk("wait_frame_done", n_done >= n, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_x", xa, 0);
        chk("rst_y", ya, 0);
        chk("rst_dat", data, 0);
        chk("rst_wr", wra, 0);
        chk("rst_busy", busya, 0);
        chk("rst_done", donea, 0);
    endtask

    // Compare process for the manual instance.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_wra = 0;
            frame_pos = 0;
        end else begin
            if (wra) begin
                chk("wr_not_adjacent", prev_wra, 0);
                chk("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("byte", data, exp_q.pop_front());
                if (frame_pos > 0) begin
                    last_gap = cyc - last_cyc;
                    chk("strobe_gap", last_gap, busy_en ? 18 : 8);
                end
                last_cyc = cyc;
                log_a.push_back(data);
                frame_pos++;
            end
            if (donea) begin
                chk("done_busy_low", busya, 0);
                chk("done_prev_busy", prev_busya, 1);
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_strobes", frame_pos, 20);
                n_done++;
                frame_pos = 0;
            end
            prev_wra = wra;
        end
        prev_busya = busya;
    end

    // Compare process for the auto-restart instance.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            kb = 0; nb_in = 0; first_b = 1; prev_doneb = 0;
        end else begin
            if (wrb) begin
                chk("b_byte", datb, exp_b[kb % 8]);
                if (!first_b) chk("b_gap", cyc - lastb, 8);
                first_b = 0;
                lastb = cyc;
                kb++;
                nb_in++;
            end
            if (prev_doneb) chk("b_idle_one_cycle", busyb, 1);
            if (doneb) begin
                chk("b_frame_strobes", nb_in, 8);
                chk("b_done_busy_low", busyb, 0);
                nb_in = 0;
                b_done++;
            end
            prev_doneb = doneb;
        end
    end

    initial begin
        int base, base2, d0;
        #1 rst = 1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        chk("rst_b_busy", busyb, 0);
        @(posedge clk); #1 rst = 0;

        busy_en = 1;
        load_frame();
        pulse_start();
        wait_wr(6);
        @(negedge clk); #2;
        chk("busy_before_reset", busya, 1);
        rst = 1;
        #1 chk_reset_outputs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 0;

        base = log_a.size();
        d0 = n_done;
        load_frame();
        pulse_start();
        wait_wr(base + 10);
        pulse_start();
        wait_done(d0 + 1);
        chk("frame_strobe_count", log_a.size() - base, 20);
        chk("lit_hdr0", log_a[base], 8'hA5);
        chk("lit_hdr1", log_a[base + 1], 8'h5A);
        chk("lit_hdr3", log_a[base + 3], 8'h0F);
        chk("lit_w0_y", log_a[base + 4], 8'h00);
        chk("lit_w0_b2", log_a[base + 6], 8'hC3);
        chk("lit_w1_x", log_a[base + 9], 8'h01);
        chk("lit_w2_y", log_a[base + 12], 8'h01);
        chk("lit_w3_last", log_a[base + 19], 8'h3C);
        repeat (100) @(negedge clk);
        chk("no_extra_strobes", log_a.size() - base, 20);
        chk("idle_after_frame", busya, 0);

        busy_en = 0;
        base2 = log_a.size();
        load_frame();
        pulse_start();
        wait_done(d0 + 2);
        chk("frame2_strobe_count", log_a.size() - base2, 20);
        chk("idle_gap_lit", last_gap, 8);
        for (int i = 0; i < 20; i++) chk("frame2_same", log_a[base2 + i], log_a[base + i]);
        chk("b_frames_seen", b_done >= 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
